// File: rtl/alu_regfile_datapath.sv
// -----------------------------------------------------------------------------
// alu_regfile_datapath
//   Execution core of the 8-bit single-cycle CPU. It contains an 8x8 register
//   file with two combinational read ports and one clocked write port, an ALU,
//   and the writeback mux that selects between the ALU result and memory data.
//
// Ports
//   CLK          system clock; all state updates on the rising edge
//   RESET        synchronous, active-low; clears every register
//   RD1_ADDR     read port 1 address
//   RD2_ADDR     read port 2 address
//   WR_ADDR      write address
//   WRITEENABLE  register write request
//   BUSYWAIT     memory stall; 1 blocks register writes
//   WB_SEL       0 = write ALU_RESULT, 1 = write READDATA
//   READDATA     data returned from data memory
//   ALU_B        ALU second operand (muxed by the control unit)
//   ALUOP        ALU operation select
//   OUT1         read port 1 data; ALU A operand and memory write data
//   OUT2         read port 2 data
//   ALU_RESULT   ALU result; also the memory address
//   ZERO         1 when ALU_RESULT == 0
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a read port whose address matches an
//   active write returns the write data combinationally (write-through).
// -----------------------------------------------------------------------------
module alu_regfile_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic              WRITEENABLE,
    input  logic              BUSYWAIT,
    input  logic              WB_SEL,
    input  logic [DATA_W-1:0] READDATA,
    input  logic [DATA_W-1:0] ALU_B,
    input  logic [2:0]        ALUOP,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic [DATA_W-1:0] ALU_RESULT,
    output logic              ZERO
);

    localparam int NREG = 2 ** ADDR_W;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    logic [DATA_W-1:0] rd1_stored;
    logic [DATA_W-1:0] rd2_stored;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;

    assign rd1_stored = regs_q[RD1_ADDR];
    assign rd2_stored = regs_q[RD2_ADDR];

    // A stalled memory access holds off the write; it lands on the first
    // edge after BUSYWAIT drops, taking whatever WDATA is present then.
    assign wr_en = WRITEENABLE & ~BUSYWAIT;
    assign wdata = WB_SEL ? READDATA : alu_res;

    // ALU. The A operand is taken from the stored register value so that the
    // optional write-through path (WDATA -> OUT1) can never form a
    // combinational loop through the ALU when WB_SEL selects the ALU result.
    always_comb begin
        alu_res = '0;
        case (ALUOP)
            OP_FWD:  alu_res = ALU_B;
            OP_ADD:  alu_res = rd1_stored + ALU_B;   // carry discarded
            OP_AND:  alu_res = rd1_stored & ALU_B;
            OP_OR:   alu_res = rd1_stored | ALU_B;
            default: alu_res = '0;                   // JUMP and reserved codes
        endcase
    end

    assign ALU_RESULT = alu_res;
    assign ZERO       = (alu_res == '0);

    // Read ports
`ifdef REGFILE_BYPASS_EN
    logic fwd_act;
    assign fwd_act = wr_en & RESET;

    always_comb begin
        OUT1 = rd1_stored;
        OUT2 = rd2_stored;
        if (fwd_act && (RD1_ADDR == WR_ADDR)) OUT1 = wdata;
        if (fwd_act && (RD2_ADDR == WR_ADDR)) OUT2 = wdata;
    end
`else
    assign OUT1 = rd1_stored;
    assign OUT2 = rd2_stored;
`endif

    // Register file next state
    always_comb begin
        for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
        if (wr_en) regs_d[WR_ADDR] = wdata;
    end

    // Reset wins over a simultaneous write.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
module tb_alu_regfile_datapath;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] RD1_ADDR, RD2_ADDR, WR_ADDR;
    logic       WRITEENABLE, BUSYWAIT, WB_SEL;
    logic [7:0] READDATA, ALU_B;
    logic [2:0] ALUOP;
    logic [7:0] OUT1, OUT2, ALU_RESULT;
    logic       ZERO;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mdl [8];

    alu_regfile_datapath #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR), .WR_ADDR(WR_ADDR),
        .WRITEENABLE(WRITEENABLE), .BUSYWAIT(BUSYWAIT), .WB_SEL(WB_SEL),
        .READDATA(READDATA), .ALU_B(ALU_B), .ALUOP(ALUOP),
        .OUT1(OUT1), .OUT2(OUT2), .ALU_RESULT(ALU_RESULT), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic       exp_zero;
    } alu_vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Reference ALU from the operation table
    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        case (op)
            3'd0: return b;
            3'd1: begin s = (int'(a) + int'(b)) % 256; return 8'(s); end
            3'd2: return a & b;
            3'd3: return a | b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic write_reg(input logic [2:0] addr, input logic [7:0] val);
        WR_ADDR = addr; WB_SEL = 1'b0; ALUOP = 3'b000; ALU_B = val;
        WRITEENABLE = 1'b1; BUSYWAIT = 1'b0;
        tick();
        WRITEENABLE = 1'b0;
    endtask

    alu_vec_t vecs [9];

    initial begin
        logic [7:0] exp1, exp2, exp_alu, wd;
        logic       wen;

        vecs[0] = '{3'b001, 8'h09, 8'h05, 8'h0E, 1'b0};
        vecs[1] = '{3'b010, 8'h09, 8'h05, 8'h01, 1'b0};
        vecs[2] = '{3'b011, 8'h09, 8'h05, 8'h0D, 1'b0};
        vecs[3] = '{3'b001, 8'h09, 8'hFB, 8'h04, 1'b0};
        vecs[4] = '{3'b001, 8'h09, 8'hF7, 8'h00, 1'b1};
        vecs[5] = '{3'b001, 8'hFF, 8'h02, 8'h01, 1'b0};
        vecs[6] = '{3'b100, 8'h09, 8'h05, 8'h00, 1'b1};
        vecs[7] = '{3'b111, 8'h09, 8'h05, 8'h00, 1'b1};
        vecs[8] = '{3'b000, 8'h09, 8'h5A, 8'h5A, 1'b0};

        RESET = 1'b0; RD1_ADDR = 0; RD2_ADDR = 0; WR_ADDR = 0;
        WRITEENABLE = 0; BUSYWAIT = 0; WB_SEL = 0; READDATA = 0; ALU_B = 0; ALUOP = 0;
        tick();
        tick();

        // Reset state
        for (int i = 0; i < 8; i++) begin
            RD1_ADDR = 3'(i); RD2_ADDR = 3'(7 - i); #1;
            chk("reset_out1", OUT1, 8'h00);
            chk("reset_out2", OUT2, 8'h00);
        end
        RESET = 1'b1;

        // Fill with 0xAA, then reset with a simultaneous write
        for (int i = 0; i < 8; i++) begin
            WR_ADDR = 3'(i); WB_SEL = 1'b1; READDATA = 8'hAA; WRITEENABLE = 1'b1;
            tick();
        end
        RD1_ADDR = 3'd6; #1;
        chk("fill_aa", OUT1, 8'hAA);
        RESET = 1'b0; WR_ADDR = 3'd3; READDATA = 8'h77; WRITEENABLE = 1'b1;
        tick();
        RESET = 1'b1; WRITEENABLE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RD1_ADDR = 3'(i); RD2_ADDR = 3'(i); #1;
            chk("reset_clr_out1", OUT1, 8'h00);
            chk("reset_clr_out2", OUT2, 8'h00);
        end

        // Write / read
        write_reg(3'd2, 8'h09);
        RD1_ADDR = 3'd2; #1;
        chk("wr_r2", OUT1, 8'h09);
        write_reg(3'd4, 8'h05);
        RD2_ADDR = 3'd4; #1;
        chk("wr_r4", OUT2, 8'h05);
        for (int i = 0; i < 8; i++) begin
            if (i != 2 && i != 4) begin
                RD1_ADDR = 3'(i); #1;
                chk("others_zero", OUT1, 8'h00);
            end
        end

        // ALU table
        for (int k = 0; k < 9; k++) begin
            write_reg(3'd7, vecs[k].a);
            RD1_ADDR = 3'd7; ALUOP = vecs[k].op; ALU_B = vecs[k].b; #1;
            chk("alu_res", ALU_RESULT, vecs[k].exp_res);
            chk("alu_zero", {7'd0, ZERO}, {7'd0, vecs[k].exp_zero});
        end

        // Stall: write held for three edges, lands after release
        write_reg(3'd1, 8'h44);
        WR_ADDR = 3'd1; WB_SEL = 1'b1; READDATA = 8'h3C; WRITEENABLE = 1'b1; BUSYWAIT = 1'b1;
        RD1_ADDR = 3'd1;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk("stall_hold", OUT1, 8'h44);
        end
        BUSYWAIT = 1'b0;
        tick();
        WRITEENABLE = 1'b0;
        chk("stall_release", OUT1, 8'h3C);

        // Same-address read during write
        write_reg(3'd5, 8'h11);
        RD1_ADDR = 3'd5; WR_ADDR = 3'd5; WB_SEL = 1'b1; READDATA = 8'h22;
        WRITEENABLE = 1'b1; BUSYWAIT = 1'b0; #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_before", OUT1, 8'h22);
`else
        chk("rdw_before", OUT1, 8'h11);
`endif
        tick();
        WRITEENABLE = 1'b0; #1;
        chk("rdw_after", OUT1, 8'h22);

        // Randomised run against the model
        RESET = 1'b0; tick(); RESET = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        for (int it = 0; it < 400; it++) begin
            RESET       = ($urandom_range(0, 49) != 0);
            RD1_ADDR    = 3'($urandom_range(0, 7));
            RD2_ADDR    = 3'($urandom_range(0, 7));
            WR_ADDR     = 3'($urandom_range(0, 7));
            WRITEENABLE = 1'($urandom_range(0, 1));
            BUSYWAIT    = ($urandom_range(0, 3) == 0);
            WB_SEL      = 1'($urandom_range(0, 1));
            READDATA    = 8'($urandom);
            ALU_B       = 8'($urandom);
            ALUOP       = 3'($urandom_range(0, 7));
            #1;
            exp_alu = ref_alu(ALUOP, mdl[RD1_ADDR], ALU_B);
            wd      = WB_SEL ? READDATA : exp_alu;
            wen     = WRITEENABLE && !BUSYWAIT;
            exp1    = mdl[RD1_ADDR];
            exp2    = mdl[RD2_ADDR];
`ifdef REGFILE_BYPASS_EN
            if (wen && RESET && RD1_ADDR == WR_ADDR) exp1 = wd;
            if (wen && RESET && RD2_ADDR == WR_ADDR) exp2 = wd;
`endif
            chk("rnd_out1", OUT1, exp1);
            chk("rnd_out2", OUT2, exp2);
            chk("rnd_alu", ALU_RESULT, exp_alu);
            chk("rnd_zero", {7'd0, ZERO}, {7'd0, (exp_alu == 8'h00)});
            tick();
            if (!RESET) begin
                for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
            end else if (wen) begin
                mdl[WR_ADDR] = wd;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
